mem_stage_pipe: RTL

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_load_align.sv | 35 +++
 rtl/mem_stage_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory pipeline stage: FSM states, access sizes and
// the byte count belonging to each size.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_e;

  localparam logic [3:0] BYTES_BYTE  = 4'd1;
  localparam logic [3:0] BYTES_HALF  = 4'd2;
  localparam logic [3:0] BYTES_WORD  = 4'd4;
  localparam logic [3:0] BYTES_DWORD = 4'd8;

  // A dword access on a 32-bit datapath degrades to a word access.
  function automatic mem_size_e clamp_size(input logic [1:0] size, input int data_w);
    if (size == 2'd3 && data_w == 32) return SZ_WORD;
    return mem_size_e'(size);
  endfunction

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    case (size)
      SZ_BYTE: return BYTES_BYTE;
      SZ_HALF: return BYTES_HALF;
      SZ_WORD: return BYTES_WORD;
      default: return BYTES_DWORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: moves the addressed byte lane to bit 0, truncates to
// the access size and zero- or sign-extends to the full datapath width.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          rdata,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic [1:0]                 size,
  input  logic                       is_unsigned,
  output logic [DATA_W-1:0]          data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [6:0]        nbits;
  logic              sign;

  // Shift, mask to the access width, then extend from the access MSB
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    nbits   = {size_bytes(mem_size_e'(size)), 3'b000};
    mask    = ~({DATA_W{1'b1}} << nbits);
    case (size)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[DATA_W-1];
    endcase
    data = shifted & mask;
    if (!is_unsigned && sign) data = data | ~mask;
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory pipeline stage: issues loads/stores from M to the data memory,
// stalls the pipe while a transfer is open and registers the W-stage result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer open; a new M instruction is evaluated
// ST_REQ   | request presented, waiting for dmem_ready_i
// ST_RESP  | load accepted, waiting for dmem_rvalid_i
// ST_DRAIN | load flushed after accept, discarding its response
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_m_i,
  input  logic                reg_write_m_i,
  input  logic                mem_to_reg_m_i,
  input  logic                mem_write_m_i,
  input  logic [2:0]          mem_size_m_i,
  input  logic [DATA_W-1:0]   alu_out_m_i,
  input  logic [DATA_W-1:0]   write_data_m_i,
  input  logic [REG_AW-1:0]   write_reg_m_i,
  input  logic                flush_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [DATA_W-1:0]   dmem_addr_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  output logic [DATA_W/8-1:0] dmem_be_o,
  input  logic                dmem_ready_i,
  input  logic                dmem_rvalid_i,
  input  logic [DATA_W-1:0]   dmem_rdata_i,
  output logic                stall_o,
  output logic                misaligned_o,
  output logic                valid_w_o,
  output logic                reg_write_w_o,
  output logic                mem_to_reg_w_o,
  output logic [DATA_W-1:0]   alu_out_w_o,
  output logic [DATA_W-1:0]   read_data_w_o,
  output logic [REG_AW-1:0]   write_reg_w_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  mem_state_e        state_q, state_d;
  mem_size_e         size_eff;
  logic              is_mem, mem_op, alu_op;
  logic              misaligned, mis_hit, done, req, stall;
  logic [OFF_W-1:0]  offset;
  logic [3:0]        nbytes;
  logic [8:0]        be_ones;
  logic [DATA_W-1:0] load_data;

  assign is_mem   = mem_to_reg_m_i | mem_write_m_i;
  assign mem_op   = valid_m_i & is_mem & ~flush_i;
  assign alu_op   = valid_m_i & ~is_mem & ~flush_i;
  assign size_eff = clamp_size(mem_size_m_i[1:0], DATA_W);
  assign offset   = alu_out_m_i[OFF_W-1:0];
  assign nbytes   = size_bytes(size_eff);
  assign be_ones  = (9'd1 << nbytes) - 9'd1;

  // An access is misaligned when its offset is not a multiple of its size
  always_comb begin
    case (size_eff)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = offset[0];
      SZ_WORD: misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

  // Request fields come straight from the M stage, which is held by stall_o
  assign dmem_addr_o  = alu_out_m_i;
  assign dmem_wdata_o = write_data_m_i << {offset, 3'b000};
  assign dmem_be_o    = be_ones[BE_W-1:0] << offset;
  assign dmem_req_o   = req & ~rst_i;
  assign dmem_we_o    = req & ~rst_i & mem_write_m_i;
  assign stall_o      = stall & ~rst_i;
  assign misaligned_o = mis_hit & ~rst_i;

  mem_load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata       (dmem_rdata_i),
    .offset      (offset),
    .size        (size_eff),
    .is_unsigned (mem_size_m_i[2]),
    .data        (load_data)
  );

  // Next state, request, stall and completion decode
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    mis_hit = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_REQ: begin
        if (alu_op) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (mem_op) begin
          if (misaligned) begin
            mis_hit = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            req = 1'b1;
            if (!dmem_ready_i) begin
              stall   = 1'b1;
              state_d = ST_REQ;
            end else if (mem_write_m_i) begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              stall   = 1'b1;
              state_d = ST_RESP;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (flush_i) begin
          state_d = dmem_rvalid_i ? ST_IDLE : ST_DRAIN;
        end else if (dmem_rvalid_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        stall = 1'b1;
        if (dmem_rvalid_i) state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // W-stage registers: completed instruction or a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_w_o      <= 1'b0;
      reg_write_w_o  <= 1'b0;
      mem_to_reg_w_o <= 1'b0;
      alu_out_w_o    <= '0;
      read_data_w_o  <= '0;
      write_reg_w_o  <= '0;
    end else if (done) begin
      valid_w_o      <= 1'b1;
      reg_write_w_o  <= reg_write_m_i & ~mis_hit;
      mem_to_reg_w_o <= mem_to_reg_m_i;
      alu_out_w_o    <= alu_out_m_i;
      read_data_w_o  <= (state_q == ST_RESP) ? load_data : '0;
      write_reg_w_o  <= write_reg_m_i;
    end else begin
      valid_w_o      <= 1'b0;
      reg_write_w_o  <= 1'b0;
      mem_to_reg_w_o <= 1'b0;
      alu_out_w_o    <= '0;
      read_data_w_o  <= '0;
      write_reg_w_o  <= '0;
    end
  end

endmodule
